sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 103 ++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// SwDebounce (module sw_debounce)
//
// Purpose:
//   Debounces three raw board switches. Each switch is first brought into the
//   clk domain through a two-flop synchronizer. A new level is accepted only
//   after the synchronized input has disagreed with the current debounced
//   level for DEBOUNCE_CNT consecutive clock edges. A single registered pulse
//   flags every edge on which at least one debounced level changed.
//
// Parameters:
//   DEBOUNCE_CNT  consecutive mismatching cycles needed to accept a new level
//                 (legal range 1..65535)
//
// Ports:
//   clk         in   1  system clock, all state updates on its rising edge
//   rst_n       in   1  asynchronous active-low reset
//   sw_raw      in   3  raw, unsynchronized switches, bit i = switch i
//   sw0         out  1  debounced switch 0
//   sw1         out  1  debounced switch 1
//   sw2         out  1  debounced switch 2
//   sw_changed  out  1  one-cycle pulse in the cycle after any debounced change
//   sw_code     out  3  packed {sw2, sw1, sw0}
// ---------------------------------------------------------------------------
module sw_debounce #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_raw,
    output logic       sw0,
    output logic       sw1,
    output logic       sw2,
    output logic       sw_changed,
    output logic [2:0] sw_code
);

    // Terminal count value: reaching it while still mismatching accepts the level.
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CNT - 1);

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_deb;
    logic [15:0] r_cnt [3];
    logic        r_changed;

    logic [2:0]  w_debNext;
    logic [15:0] w_cntNext [3];
    logic        w_anyChange;

    // Two-flop synchronizer per switch; only the second stage feeds the
    // debounce logic so metastability on the first stage never propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce decision. Agreement discards any partial count.
    // Disagreement counts up until the terminal value, at which point the new
    // level is taken and the counter restarts; the >= compare keeps the counter
    // from ever passing the terminal value.
    always_comb begin
        w_debNext = r_deb;
        for (int i = 0; i < 3; i++) begin
            w_cntNext[i] = '0;
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] >= CNT_LAST) begin
                    w_debNext[i] = r_sync2[i];
                end else begin
                    w_cntNext[i] = r_cnt[i] + 16'd1;
                end
            end
        end
        w_anyChange = |(w_debNext ^ r_deb);
    end

    // Debounced levels, counters and the change pulse. The pulse is computed
    // from the same edge's update so several channels flipping together give
    // a single pulse, and it lasts one cycle because the levels stop differing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb     <= '0;
            r_cnt     <= '{default: '0};
            r_changed <= 1'b0;
        end else begin
            r_deb     <= w_debNext;
            r_cnt     <= w_cntNext;
            r_changed <= w_anyChange;
        end
    end

    assign sw0        = r_deb[0];
    assign sw1        = r_deb[1];
    assign sw2        = r_deb[2];
    assign sw_code    = r_deb;
    assign sw_changed = r_changed;

endmodule
